// File: rtl/instr_fetch_mem.sv
// Instruction memory for the matrix-multiply core: a streaming load port fills the
// byte array, and a fetch port returns FETCH_BYTES consecutive bytes one cycle later.
module instr_fetch_mem #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 8,
    parameter int WR_BYTES    = 2,
    parameter int FETCH_BYTES = 2
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              ld_start_i,
    input  logic [ADDR_WIDTH-1:0]             ld_base_i,
    input  logic                              ld_valid_i,
    output logic                              ld_ready_o,
    input  logic [WR_BYTES*DATA_WIDTH-1:0]    ld_data_i,
    input  logic                              ld_last_i,
    output logic                              ld_done_o,
    output logic                              ld_wrap_o,
    output logic [ADDR_WIDTH:0]               ld_beats_o,
    input  logic                              f_req_i,
    input  logic [ADDR_WIDTH-1:0]             f_addr_i,
    output logic                              f_gnt_o,
    output logic                              f_valid_o,
    output logic [FETCH_BYTES*DATA_WIDTH-1:0] f_data_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] BEATS_MAX = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic {
        IDLE,
        LOAD
    } state_e;

    state_e                           state_q;
    logic [ADDR_WIDTH-1:0]            ptr_q;
    logic [ADDR_WIDTH:0]              beats_q;
    logic                             wrap_q;
    logic                             ready_q;
    logic                             done_q;
    logic                             fValid_q;
    logic [FETCH_BYTES*DATA_WIDTH-1:0] fData_q;
    logic [DATA_WIDTH-1:0]            mem [DEPTH];

    logic beatAccept;
    logic fetchGrant;
    logic ptrCrossesTop;

    assign f_gnt_o       = (state_q == IDLE) && !ld_start_i;
    assign fetchGrant    = f_gnt_o && f_req_i;
    assign beatAccept    = (state_q == LOAD) && ld_valid_i && ready_q;
    assign ptrCrossesTop = (int'(ptr_q) + WR_BYTES) >= DEPTH;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            beats_q  <= '0;
            wrap_q   <= 1'b0;
            ready_q  <= 1'b0;
            done_q   <= 1'b0;
            fValid_q <= 1'b0;
            fData_q  <= '0;
        end else begin
            done_q   <= 1'b0;
            fValid_q <= fetchGrant;
            if (fetchGrant) begin
                for (int i = 0; i < FETCH_BYTES; i++) begin
                    fData_q[i*DATA_WIDTH +: DATA_WIDTH] <= mem[f_addr_i + ADDR_WIDTH'(i)];
                end
            end
            case (state_q)
                IDLE: begin
                    if (ld_start_i) begin
                        state_q <= LOAD;
                        ready_q <= 1'b1;
                        ptr_q   <= ld_base_i;
                        beats_q <= '0;
                        wrap_q  <= 1'b0;
                    end
                end
                LOAD: begin
                    if (beatAccept) begin
                        ptr_q <= ptr_q + ADDR_WIDTH'(WR_BYTES);
                        if (beats_q != BEATS_MAX) begin
                            beats_q <= beats_q + (ADDR_WIDTH + 1)'(1);
                        end
                        if (ptrCrossesTop) begin
                            wrap_q <= 1'b1;
                        end
                        if (ld_last_i) begin
                            state_q <= IDLE;
                            ready_q <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Storage is never cleared; a beat coinciding with reset is dropped with its session.
    always_ff @(posedge clk_i) begin
        if (!rst_i && beatAccept) begin
            for (int i = 0; i < WR_BYTES; i++) begin
                mem[ptr_q + ADDR_WIDTH'(i)] <= ld_data_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign ld_ready_o = ready_q;
    assign ld_done_o  = done_q;
    assign ld_wrap_o  = wrap_q;
    assign ld_beats_o = beats_q;
    assign f_valid_o  = fValid_q;
    assign f_data_o   = fData_q;

endmodule

// File: doc/instr_fetch_mem.md
# instr_fetch_mem

Parametrised instruction memory for the single-core matrix-multiply processor. Its byte array is filled through a streaming load port with a valid/ready handshake and an auto-incrementing pointer. The core reads it through a fetch port that returns FETCH_BYTES consecutive bytes (opcode plus operands) one cycle after a granted request. A two-state controller keeps loading and fetching mutually exclusive, with defined wrap-around and abort behaviour.

## Interface

- DATA_WIDTH, 8: width of one memory byte/word.
- ADDR_WIDTH, 8: address width; depth = 2**ADDR_WIDTH.
- WR_BYTES, 2: bytes written per load beat (≥1).
- FETCH_BYTES, 2: bytes returned per fetch (≥1).

- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- ld_start  in  1  start a load session at ld_base (honoured only in IDLE).
- ld_base  in  ADDR_WIDTH  first byte address of the session.
- ld_valid  in  1  load beat valid.
- ld_ready  out  1  block accepts a beat (registered; high only in LOAD).
- ld_data  in  WR_BYTES*DATA_WIDTH  beat payload; byte i = ld_data[i*DATA_WIDTH +: DATA_WIDTH].
- ld_last  in  1  qualifies the final beat of the session.
- ld_done  out  1  one-cycle pulse after the last beat is written.
- ld_wrap  out  1  sticky per session; pointer crossed the top address.
- ld_beats  out  ADDR_WIDTH+1  beats accepted in current/last session (saturating).
- f_req  in  1  fetch request.
- f_addr  in  ADDR_WIDTH  fetch byte address.
- f_gnt  out  1  combinational grant = (state==IDLE) && !ld_start.
- f_valid  out  1  f_data valid (one cycle after a granted request).
- f_data  out  FETCH_BYTES*DATA_WIDTH  byte i = mem[(f_addr+i) mod depth].

## Operation

- Storage: 2**ADDR_WIDTH × DATA_WIDTH array. Contents are not cleared by rst and are undefined after power-up.
- States:
  - IDLE: fetch enabled. ld_start=1 loads ptr←ld_base, ld_beats←0, ld_wrap←0, and moves to LOAD.
  - LOAD: ld_ready=1, fetch disabled.
- Beat acceptance (LOAD, ld_valid && ld_ready):
  - Byte i is written to mem[(ptr+i) mod depth].
  - ptr ← (ptr+WR_BYTES) mod depth.
  - ld_beats increments, saturating at 2**ADDR_WIDTH.
  - ld_wrap sets if ptr+WR_BYTES ≥ depth.
- Lower-index bytes go to lower addresses (little-endian, low byte at base).
- Accepted beat with ld_last=1: go to IDLE; ld_done=1 on the next cycle.
- ld_last without ld_valid is ignored. ld_start in LOAD is ignored.
- Fetch (IDLE, f_req && f_gnt): next cycle f_valid=1 and f_data=FETCH_BYTES bytes from f_addr, wrapping mod depth.
- f_data holds its last value while f_valid=0. f_valid is 0 whenever the previous cycle had no granted request.
- ld_start and f_req asserted together in IDLE: ld_start wins, f_gnt=0, and no fetch is issued.
- Reset, including mid-load:
  - Next state IDLE.
  - ld_ready=0, ld_done=0, ld_wrap=0, ld_beats=0, f_valid=0, f_data=0.
  - Bytes already written are retained. A partial session is abandoned, not completed.

## Timing

- Load write: takes effect at the clock edge of the handshake. Throughput 1 beat/cycle.
- ld_ready: rises the cycle after ld_start is accepted and falls the cycle after the last-beat handshake.
- Read-after-load: a fetch granted in the first IDLE cycle after the last beat returns the newly written data.
- Fetch latency: 1 cycle (registered read). Throughput 1 fetch/cycle in IDLE.
- ld_done: coincides with the first IDLE cycle after LOAD.
- ld_beats and ld_wrap: remain stable in IDLE until the next ld_start.

## Test plan

- Reset then fetch: rst 1 cycle; f_addr=0x00, f_req=1 -> f_gnt=1; next cycle f_valid=1. All status outputs are 0 during reset.
- Basic load/fetch (WR_BYTES=2, FETCH_BYTES=2):
  - Stimulus: ld_start with ld_base=0x10; beats 0x1A00, 0x021B; second beat has ld_last=1.
  - Expect mem[0x10..0x13]=00,1A,1B,02 and ld_done pulse. ld_beats=2, ld_wrap=0.
  - Then fetch 0x11 -> f_data=0x1B1A.
- Wrap-around: ld_base=0xFF, one beat 0xBBAA with ld_last=1 -> mem[0xFF]=AA, mem[0x00]=BB, ld_wrap=1. Fetch 0xFF -> f_data=0xBBAA.
- Back-pressure and mutual exclusion:
  - ld_valid toggles 1,0,1 with ld_last on the 3rd cycle -> exactly 2 beats written.
  - f_req held high throughout -> f_gnt=0 and f_valid=0 for the whole LOAD.
  - First f_valid occurs one cycle after return to IDLE.
- Collision: in IDLE, ld_start=1 and f_req=1 together -> f_gnt=0, no f_valid next cycle, ld_ready=1 next cycle.
- Reset mid-load: 1 beat accepted at 0x20, rst on the 2nd -> the first beat's bytes persist. State IDLE, ld_ready=0, ld_beats=0. A further ld_valid causes no write.
